// File: rtl/demorgan_chk_pkg.sv
// Shared types and helpers for the De Morgan gate response checker.
// The state encoding is fixed at 3 bits so it can be probed on a debug bus.
package demorgan_chk_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] COMBO_ALL = 4'hF;

  function automatic logic exp_e(input logic a, input logic b);
    return ~(a & b);
  endfunction

endpackage

// File: rtl/demorgan_resp_checker_sync_2ff.sv
// Two-flop synchroniser bank for signals that are asynchronous to clk.
// Each bit is synchronised independently; there is no cross-bit coherency.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/demorgan_resp_checker.sv
// Response checker for a two-input De Morgan gate: waits for {a,b} to settle,
// then compares e against ~(a & b), tracking coverage, mismatches and stalls.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// ARMED  | vector checked, waiting for the next input change (idle timer runs)
// SETTLE | {a,b} changed, counting stable cycles before sampling e
// CHECK  | one-cycle compare of e against the expected value
// DONE   | all combinations covered or timed out; results held
module demorgan_resp_checker
  import demorgan_chk_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             e_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       cov_mask,
  output logic [2:0]       last_err
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [7:0]        SETTLE_LD = 8'(SETTLE_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_LD   = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  logic [2:0] abe_s;
  logic       a_s, b_s, e_s;
  logic [1:0] ab_s, ab_q;
  logic       chg;

  state_t            state, state_nxt;
  logic [7:0]        settle_cnt, settle_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic              chg_pending, pend_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;
  logic [3:0]        cov_nxt;
  logic              timeout_nxt, err_pulse_nxt;
  logic [2:0]        last_err_nxt;

  sync_2ff #(.W(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({a_in, b_in, e_in}),
    .q     (abe_s)
  );

  assign {a_s, b_s, e_s} = abe_s;
  assign ab_s = {a_s, b_s};
  assign chg  = (ab_s != ab_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ab_q        <= '0;
      settle_cnt  <= '0;
      idle_cnt    <= '0;
      chg_pending <= 1'b0;
      err_cnt     <= '0;
      cov_mask    <= '0;
      timeout     <= 1'b0;
      err_pulse   <= 1'b0;
      last_err    <= '0;
    end else begin
      state       <= state_nxt;
      ab_q        <= ab_s;
      settle_cnt  <= settle_nxt;
      idle_cnt    <= idle_nxt;
      chg_pending <= pend_nxt;
      err_cnt     <= err_cnt_nxt;
      cov_mask    <= cov_nxt;
      timeout     <= timeout_nxt;
      err_pulse   <= err_pulse_nxt;
      last_err    <= last_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    settle_nxt    = settle_cnt;
    idle_nxt      = idle_cnt;
    pend_nxt      = 1'b0;
    err_cnt_nxt   = err_cnt;
    cov_nxt       = cov_mask;
    timeout_nxt   = timeout;
    err_pulse_nxt = 1'b0;
    last_err_nxt  = last_err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          err_cnt_nxt  = '0;
          cov_nxt      = '0;
          timeout_nxt  = 1'b0;
          last_err_nxt = '0;
          settle_nxt   = SETTLE_LD;
          state_nxt    = SETTLE;
        end
      end
      ARMED: begin
        // chg_pending carries a change that landed during CHECK, after ab_q moved on
        if (chg || chg_pending) begin
          settle_nxt = SETTLE_LD;
          idle_nxt   = IDLE_LD;
          state_nxt  = SETTLE;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (idle_cnt == IDLE_W'(1)) begin
            timeout_nxt = 1'b1;
            state_nxt   = DONE;
          end else begin
            idle_nxt = idle_cnt - IDLE_W'(1);
          end
        end
      end
      SETTLE: begin
        if (chg)
          settle_nxt = SETTLE_LD;
        else if (settle_cnt <= 8'd1)
          state_nxt = CHECK;
        else
          settle_nxt = settle_cnt - 8'd1;
      end
      CHECK: begin
        cov_nxt[ab_s] = 1'b1;
        pend_nxt      = chg;
        if (e_s != exp_e(a_s, b_s)) begin
          err_pulse_nxt = 1'b1;
          last_err_nxt  = {a_s, b_s, e_s};
          if (err_cnt != ERR_MAX)
            err_cnt_nxt = err_cnt + ERR_W'(1);
        end
        if (cov_nxt == COMBO_ALL) begin
          state_nxt = DONE;
        end else begin
          idle_nxt  = IDLE_LD;
          state_nxt = ARMED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == ARMED) || (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (cov_mask == COMBO_ALL) && (err_cnt == '0);

endmodule
